// File: rtl/dtw_scheduler.sv
// DTW matrix scheduler: streams row-major local distances through one DTW cell evaluator.
// Optional path-code output stream is compiled in with `define DTW_PATH_OUT_EN.
`ifndef DTW_WIDTH
`define DTW_WIDTH 16
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 8
`endif

module dtw_scheduler #(
  parameter int unsigned COLS  = 16,
  parameter int unsigned ROW_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       dist_valid,
  output logic                       dist_ready,
  input  logic [`DISTANCE_WIDTH-1:0] distance,
  input  logic                       last_row,
  output logic                       busy,
  output logic                       done,
  output logic [`DTW_WIDTH-1:0]      result,
  output logic [ROW_W-1:0]           row_count,
  output logic                       path_valid,
  output logic [1:0]                 path_num
);

  localparam int unsigned DW     = `DTW_WIDTH;
  localparam int unsigned DIST_W = `DISTANCE_WIDTH;
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [DW-1:0]    ONES     = '1;
  localparam logic [ROW_W-1:0] ROW_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DW-1:0]     diag_q, diag_d;
  logic [DW-1:0]     left_q, left_d;
  logic [DW-1:0]     result_q, result_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     row_buf_q [COLS];

  logic              accept_c;
  logic              first_row_c;
  logic              first_col_c;
  logic [DW-1:0]     pre_left_c;
  logic [DW-1:0]     pre_diag_c;
  logic [DW-1:0]     pre_up_c;
  logic [DW-1:0]     cell_c;
  logic [1:0]        cell_path_c;

  assign accept_c    = ready_q & dist_valid;
  assign first_row_c = (row_q == '0);
  assign first_col_c = (col_q == '0);

  // Predecessor selection; out-of-range neighbours read as all-ones, except the (0,0) diagonal.
  always_comb begin
    pre_left_c = first_col_c ? ONES : left_q;
    pre_up_c   = first_row_c ? ONES : row_buf_q[col_q];
    if (first_col_c) begin
      pre_diag_c = first_row_c ? '0 : ONES;
    end else begin
      pre_diag_c = first_row_c ? ONES : diag_q;
    end
  end

  DTWCalculator #(
    .DIST_W (DIST_W),
    .DTW_W  (DW)
  ) u_calc (
    .distance  (distance),
    .pre_DTW_0 (pre_left_c),
    .pre_DTW_1 (pre_diag_c),
    .pre_DTW_2 (pre_up_c),
    .DTW       (cell_c),
    .path      (cell_path_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    diag_d   = diag_q;
    left_d   = left_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          col_d    = '0;
          row_d    = '0;
          diag_d   = '0;
          left_d   = '0;
          result_d = '0;
        end
      end
      ST_RUN: begin
        if (accept_c) begin
          // Old entry j becomes the diagonal of cell j+1 once this cell overwrites it.
          diag_d = row_buf_q[col_q];
          left_d = cell_c;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q != ROW_MAX) begin
              row_d = row_q + ROW_W'(1);
            end
            if (last_row) begin
              state_d  = ST_DONE;
              result_d = cell_c;
              done_d   = 1'b1;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      diag_q   <= '0;
      left_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      diag_q   <= diag_d;
      left_q   <= left_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Previous-row buffer; contents before the first row completes are never read.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      row_buf_q[col_q] <= cell_c;
    end
  end

  assign dist_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign row_count  = row_q;

`ifdef DTW_PATH_OUT_EN
  logic       path_valid_q;
  logic [1:0] path_num_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      path_valid_q <= 1'b0;
      path_num_q   <= 2'b00;
    end else begin
      path_valid_q <= accept_c;
      if (accept_c) begin
        path_num_q <= cell_path_c;
      end
    end
  end

  assign path_valid = path_valid_q;
  assign path_num   = path_num_q;
`else
  logic unused_path_c;
  assign unused_path_c = ^cell_path_c;
  assign path_valid    = 1'b0;
  assign path_num      = 2'b00;
`endif

endmodule

// One DTW cell: D = d + min(left, diag, up), saturating; ties favour diagonal, then left.
module DTWCalculator #(
  parameter int unsigned DIST_W = 8,
  parameter int unsigned DTW_W  = 16
) (
  input  logic [DIST_W-1:0] distance,
  input  logic [DTW_W-1:0]  pre_DTW_0,
  input  logic [DTW_W-1:0]  pre_DTW_1,
  input  logic [DTW_W-1:0]  pre_DTW_2,
  output logic [DTW_W-1:0]  DTW,
  output logic [1:0]        path
);

  logic [DTW_W-1:0] min_c;
  logic [DTW_W-1:0] dist_ext_c;
  logic [DTW_W-1:0] sum_c;

  always_comb begin
    min_c = pre_DTW_1;
    path  = 2'b01;
    if (pre_DTW_0 < min_c) begin
      min_c = pre_DTW_0;
      path  = 2'b00;
    end
    if (pre_DTW_2 < min_c) begin
      min_c = pre_DTW_2;
      path  = 2'b10;
    end
    dist_ext_c = DTW_W'(distance);
    sum_c      = dist_ext_c + min_c;
    DTW        = (sum_c < dist_ext_c) ? '1 : sum_c;
  end

endmodule

// File: tb/tb_dtw_scheduler.sv
// Self-checking bench for dtw_scheduler: matrix-level DTW model, per-cycle compare, directed runs.
`ifndef DTW_WIDTH
`define DTW_WIDTH 16
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 8
`endif

module tb_dtw_scheduler;

  localparam int     COLS   = 4;
  localparam int     ROW_W  = 16;
  localparam int     DIST_W = `DISTANCE_WIDTH;
  localparam int     DTW_W  = `DTW_WIDTH;
  localparam int     MAXR   = 300;
  localparam longint ONES   = (longint'(1) << DTW_W) - 1;
  localparam longint RMAX   = (longint'(1) << ROW_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              dist_valid = 1'b0;
  logic              dist_ready;
  logic [DIST_W-1:0] distance = '0;
  logic              last_row = 1'b0;
  logic              busy;
  logic              done;
  logic [DTW_W-1:0]  result;
  logic [ROW_W-1:0]  row_count;
  logic              path_valid;
  logic [1:0]        path_num;

  dtw_scheduler #(.COLS(COLS), .ROW_W(ROW_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dist_valid (dist_valid),
    .dist_ready (dist_ready),
    .distance   (distance),
    .last_row   (last_row),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .row_count  (row_count),
    .path_valid (path_valid),
    .path_num   (path_num)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  p;
    logic [63:0] d;
  } cell_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  cell_t  exp_q[$];
  longint dm [0:MAXR-1][0:COLS-1];
  int     pm [0:MAXR-1][0:COLS-1];

  bit     mon_en   = 1'b0;
  bit     exp_run  = 1'b0;
  bit     exp_done = 1'b0;
  bit     exp_pv   = 1'b0;
  int     exp_pn   = 0;
  longint exp_res  = 0;
  longint exp_rows = 0;
  int     exp_col  = 0;
  longint got_result = -1;
  longint got_rows   = -1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic int dist_of(input int mode, input int i, input int j);
    case (mode)
      0:       return 1;
      1:       return j + 1;
      2:       return 255;
      default: return (i * 7 + j * 3) % 11;
    endcase
  endfunction

  // Whole-matrix DTW recurrence; path = first of diagonal/left/up that attains the minimum.
  function automatic void model_matrix(input int nrows, input int mode);
    longint lf, up, dg, m, s;
    cell_t  c;
    for (int i = 0; i < nrows; i++) begin
      for (int j = 0; j < COLS; j++) begin
        lf = (j > 0) ? dm[i][j-1] : ONES;
        up = (i > 0) ? dm[i-1][j] : ONES;
        if (i > 0 && j > 0)       dg = dm[i-1][j-1];
        else if (i == 0 && j == 0) dg = 0;
        else                       dg = ONES;
        m = dg;
        if (lf < m) m = lf;
        if (up < m) m = up;
        s = longint'(dist_of(mode, i, j)) + m;
        if (s > ONES) s = ONES;
        dm[i][j] = s;
        pm[i][j] = (dg == m) ? 1 : ((lf == m) ? 0 : 2);
        c.p = 2'(pm[i][j]);
        c.d = 64'(s);
        exp_q.push_back(c);
      end
    end
  endfunction

  // Protocol-level expectations advanced at each rising edge from the bench's own stimulus.
  always @(posedge clk) begin
    bit    was_done;
    cell_t cur;
    was_done = exp_done;
    exp_done = 1'b0;
    exp_pv   = 1'b0;
    if (rst) begin
      exp_run  = 1'b0;
      exp_rows = 0;
      exp_col  = 0;
      exp_q.delete();
    end else if (exp_run) begin
      if (dist_valid) begin
        cur = '0;
        if (exp_q.size() == 0) chk("model_underflow", 0, 1);
        else cur = exp_q.pop_front();
        exp_pv = 1'b1;
        exp_pn = int'(cur.p);
        if (exp_col == COLS - 1) begin
          exp_col = 0;
          if (exp_rows != RMAX) exp_rows++;
          if (last_row) begin
            exp_run  = 1'b0;
            exp_done = 1'b1;
            exp_res  = longint'(cur.d);
          end
        end else begin
          exp_col++;
        end
      end
    end else if (!was_done && start) begin
      exp_run  = 1'b1;
      exp_rows = 0;
      exp_col  = 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("dist_ready", dist_ready, exp_run);
      chk("busy", busy, exp_run);
      chk("done", done, exp_done);
      chk("row_count", row_count, exp_rows);
`ifdef DTW_PATH_OUT_EN
      chk("path_valid", path_valid, exp_pv);
      if (exp_pv) chk("path_num", path_num, exp_pn);
`else
      chk("path_valid_off", path_valid, 0);
      chk("path_num_off", path_num, 0);
`endif
      if (exp_done) begin
        chk("result", result, exp_res);
        got_result = result;
        got_rows   = row_count;
      end
    end
  end

  task automatic run_matrix(input int nrows, input int mode, input bit gaps, input bit hold);
    got_result = -1;
    got_rows   = -1;
    model_matrix(nrows, mode);
    start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    for (int i = 0; i < nrows; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if (gaps) begin
          dist_valid = 1'b0;
          distance   = DIST_W'($urandom);
          last_row   = 1'($urandom);
          @(posedge clk); #1;
        end
        dist_valid = 1'b1;
        distance   = DIST_W'(dist_of(mode, i, j));
        last_row   = (i == nrows - 1);
        @(posedge clk); #1;
      end
    end
    dist_valid = 1'b0;
    last_row   = 1'b0;
    start      = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("beats_left", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_path_num", path_num, 0);
    chk("rst_path_valid", path_valid, 0);
    @(posedge clk); #1;

    // 4x4 all-ones matrix.
    run_matrix(4, 0, 1'b0, 1'b0);
    chk("m44_model_d33", dm[3][3], 4);
    chk("m44_model_p00", pm[0][0], 1);
    chk("m44_model_p01", pm[0][1], 0);
    chk("m44_model_p10", pm[1][0], 2);
    chk("m44_model_p11", pm[1][1], 1);
    chk("m44_result", got_result, 4);
    chk("m44_rows", got_rows, 4);

    // Single row 1,2,3,4.
    run_matrix(1, 1, 1'b0, 1'b0);
    chk("row1_model_d03", dm[0][3], 10);
    chk("row1_model_p01", pm[0][1], 0);
    chk("row1_model_p03", pm[0][3], 0);
    chk("row1_result", got_result, 10);
    chk("row1_rows", got_rows, 1);
    chk("row1_held", result, 10);

    // 4x4 all-ones with idle cycles interleaved.
    run_matrix(4, 0, 1'b1, 1'b0);
    chk("gap_result", got_result, 4);
    chk("gap_rows", got_rows, 4);

    // start held high throughout RUN.
    run_matrix(4, 0, 1'b0, 1'b1);
    chk("hold_result", got_result, 4);

    // Abort after 6 beats, then a fresh single-row matrix.
    model_matrix(3, 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      dist_valid = 1'b1;
      distance   = DIST_W'(dist_of(3, k / COLS, k % COLS));
      last_row   = 1'b0;
      @(posedge clk); #1;
    end
    dist_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_result", result, 0);
    chk("abort_rows", row_count, 0);
    @(posedge clk); #1;
    run_matrix(1, 1, 1'b0, 1'b0);
    chk("abort_new_result", got_result, 10);
    chk("abort_new_rows", got_rows, 1);

    // Mixed distances with gaps.
    run_matrix(5, 3, 1'b1, 1'b0);
    chk("mix_rows", got_rows, 5);

    // Long all-255 matrix drives the sum past the DTW width.
    run_matrix(260, 2, 1'b0, 1'b0);
    chk("sat_model_d2553", dm[255][3], 65280);
    chk("sat_result", got_result, ONES);
    chk("sat_rows", got_rows, 260);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dtw_scheduler.md
DTW_SCHEDULER -- requirements
Module: dtw_scheduler

Interface
REQ-001 SHALL provide parameter COLS, default 16: template length, i.e. cells per DTW matrix row (2..256).
REQ-002 SHALL provide parameter ROW_W, default 16: width of the row counter.
REQ-003 SHALL size DTW values by `dtw_width and distances by `distance_width.
REQ-004 SHALL have a single clock and a synchronous, active-high reset, as below.
- clk  input  1  sole clock; rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new matrix; sampled in IDLE only.
- dist_valid  input  1  distance beat present.
- dist_ready  output  1  beat accepted when dist_valid && dist_ready.
- distance  input  `distance_width  local distance d(i,j), row-major.
- last_row  input  1  qualifies the current beat as belonging to the final row.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse: result valid.
- result  output  `dtw_width  D(last row, COLS-1), held until next start.
- row_count  output  ROW_W  rows completed in the current or last matrix.
- path_valid  output  1  path beat valid.
- path_num  output  2  predecessor code of the cell just computed.

Function
REQ-005 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on accepting the beat with col==COLS-1 and last_row=1; DONE -> IDLE unconditionally after one cycle.
REQ-006 SHALL drive dist_ready=1 in RUN only; start in RUN/DONE is ignored.
REQ-007 SHALL instantiate one DTWCalculator and evaluate one cell per accepted beat, same cycle; idle cycles (dist_valid=0) leave all state unchanged.
REQ-008 SHALL present pre_DTW_0=left D(i,j-1), pre_DTW_1=diagonal D(i-1,j-1), pre_DTW_2=up D(i-1,j); path code 00=left, 01=diagonal, 10=up.
REQ-009 SHALL substitute all-ones for out-of-range predecessors, except that the diagonal of cell (0,0) SHALL be 0.
REQ-010 SHALL keep the previous row in a COLS-entry row buffer; D(i,j) overwrites entry j on acceptance; the diagonal is held in a register captured from entry j before overwrite.
REQ-011 SHALL saturate a cell to all-ones when distance + min wraps (sum < distance).
REQ-012 SHALL wrap col from COLS-1 to 0 and increment row_count on each completed row; row_count saturates at all-ones.
REQ-013 SHALL register result and pulse done in the cycle after the final beat (DONE state); busy=0 in DONE.
REQ-014 SHALL assert path_valid for one cycle, one cycle after each accepted beat, with that cell's path_num; no backpressure on the path stream.
REQ-015 SHALL on start clear col, row_count, diagonal and left registers; row-buffer contents are don't-care since row 0 never reads them.

Reset
REQ-016 SHALL on rst return to IDLE from any state, abandoning any matrix in progress.
REQ-017 SHALL reset outputs: dist_ready=0, busy=0, done=0, result=0, row_count=0, path_valid=0, path_num=00.

Configuration
REQ-018 SHALL compile path output only when DTW_PATH_OUT_EN is defined; without it, path_valid and path_num SHALL be tied to 0, the ports SHALL remain, and the path registers SHALL be absent.

Verification
REQ-019 COLS=4; 4 rows, all distances 1, last_row set on row 3 -> result=4, done one cycle after the 16th beat, row_count=4; path_num: (0,0)=01, (0,1)=00, (1,0)=10, (1,1)=01.
REQ-020 COLS=4; single row with distances 1,2,3,4 and last_row=1 -> result=10; path_num sequence 01,00,00,00.
REQ-021 Same stimulus as REQ-019 with dist_valid low on alternate cycles -> identical result and path sequence; no state change on idle cycles.
REQ-022 rst pulsed after 6 beats, then start and the REQ-020 stimulus -> result=10, row_count=1, no residue from the aborted run.
REQ-023 start held high in RUN -> no restart; build without DTW_PATH_OUT_EN -> path_valid stays 0 and result is unchanged.
